// File: rtl/score_keeper_if.sv
// Bundle of frame-timing, control and hit inputs plus the score/match outputs
// shared between the game-control logic and the score_keeper.
interface score_keeper_if;
  logic       fsync;
  logic       start;
  logic       p1_hit;
  logic       p2_hit;
  logic [3:0] player_1_score;
  logic [3:0] player_2_score;
  logic       game_over;
  logic [1:0] winner;
  logic       play_en;

  modport master (
    output fsync, start, p1_hit, p2_hit,
    input  player_1_score, player_2_score, game_over, winner, play_en
  );

  modport slave (
    input  fsync, start, p1_hit, p2_hit,
    output player_1_score, player_2_score, game_over, winner, play_en
  );
endinterface

// File: rtl/score_keeper.sv
// Match controller: edge-detects start/hit levels, keeps 0..WIN_SCORE scores,
// and sequences IDLE -> PLAY -> LOCKOUT/OVER with a frame-counted freeze.
module score_keeper #(
  parameter int unsigned WIN_SCORE      = 9,
  parameter int unsigned LOCKOUT_FRAMES = 30
) (
  input  logic pixel_clk,
  input  logic rst,
  score_keeper_if.slave bus
);

  localparam logic [3:0] WIN_VAL  = 4'(WIN_SCORE);
  localparam logic [7:0] LOCK_VAL = 8'(LOCKOUT_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_LOCKOUT = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] p1_score_reg, p1_score_next;
  logic [3:0] p2_score_reg, p2_score_next;
  logic [1:0] winner_reg, winner_next;
  logic [7:0] lock_cnt_reg, lock_cnt_next;

  // Bit order: 0 = start, 1 = p1_hit, 2 = p2_hit.
  logic [2:0] level_in;
  logic [2:0] edge_det;

  assign level_in = {bus.p2_hit, bus.p1_hit, bus.start};

  // Previous-value registers reset to 0, so a level already high at reset
  // release is seen as an edge on the first sampled cycle.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
      logic prev_reg;
      always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) prev_reg <= 1'b0;
        else      prev_reg <= level_in[gi];
      end
      assign edge_det[gi] = level_in[gi] & ~prev_reg;
    end
  endgenerate

  logic start_edge, p1_edge, p2_edge;
  assign start_edge = edge_det[0];
  assign p1_edge    = edge_det[1];
  assign p2_edge    = edge_det[2];

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v >= WIN_VAL) return WIN_VAL;
    return v + 4'd1;
  endfunction

  always_ff @(posedge pixel_clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      p1_score_reg <= 4'd0;
      p2_score_reg <= 4'd0;
      winner_reg   <= 2'b00;
      lock_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      p1_score_reg <= p1_score_next;
      p2_score_reg <= p2_score_next;
      winner_reg   <= winner_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end

  logic [3:0] p1_cand, p2_cand;
  logic       p1_won, p2_won;

  always_comb begin
    state_next    = state_reg;
    p1_score_next = p1_score_reg;
    p2_score_next = p2_score_reg;
    winner_next   = winner_reg;
    lock_cnt_next = lock_cnt_reg;

    p1_cand = p1_edge ? sat_inc(p1_score_reg) : p1_score_reg;
    p2_cand = p2_edge ? sat_inc(p2_score_reg) : p2_score_reg;
    p1_won  = (p1_cand == WIN_VAL);
    p2_won  = (p2_cand == WIN_VAL);

    unique case (state_reg)
      ST_IDLE, ST_OVER: begin
        // start wins over any hit edge arriving in the same cycle
        if (start_edge) begin
          p1_score_next = 4'd0;
          p2_score_next = 4'd0;
          winner_next   = 2'b00;
          state_next    = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (p1_edge || p2_edge) begin
          p1_score_next = p1_cand;
          p2_score_next = p2_cand;
          if (p1_won || p2_won) begin
            state_next  = ST_OVER;
            winner_next = {p2_won, p1_won};
          end else begin
            state_next    = ST_LOCKOUT;
            lock_cnt_next = LOCK_VAL;
          end
        end
      end

      ST_LOCKOUT: begin
        if (bus.fsync && (lock_cnt_reg != 8'd0)) begin
          lock_cnt_next = lock_cnt_reg - 8'd1;
          if (lock_cnt_reg == 8'd1) state_next = ST_PLAY;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.player_1_score = p1_score_reg;
  assign bus.player_2_score = p2_score_reg;
  assign bus.winner         = winner_reg;
  assign bus.game_over      = (state_reg == ST_OVER);
  assign bus.play_en        = (state_reg == ST_PLAY);

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed match scenarios followed by
// random traffic, all compared each cycle against a behavioural match model.
module tb_score_keeper;

  localparam int W  = 9;
  localparam int LF = 30;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_LOCK = 2;
  localparam int M_OVER = 3;

  logic pixel_clk = 1'b0;
  logic rst = 1'b0;

  score_keeper_if sk_if ();

  score_keeper #(.WIN_SCORE(W), .LOCKOUT_FRAMES(LF)) dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .bus       (sk_if)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Behavioural match model
  int m_mode, m_s1, m_s2, m_win, m_left;
  bit m_prev_start, m_prev_p1, m_prev_p2;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0; m_left = 0;
    m_prev_start = 0; m_prev_p1 = 0; m_prev_p2 = 0;
  endtask

  task automatic model_step();
    bit ev_s, ev_1, ev_2;
    ev_s = sk_if.start  && !m_prev_start;
    ev_1 = sk_if.p1_hit && !m_prev_p1;
    ev_2 = sk_if.p2_hit && !m_prev_p2;
    m_prev_start = sk_if.start;
    m_prev_p1    = sk_if.p1_hit;
    m_prev_p2    = sk_if.p2_hit;
    if (m_mode == M_IDLE || m_mode == M_OVER) begin
      if (ev_s) begin
        m_s1 = 0; m_s2 = 0; m_win = 0; m_mode = M_PLAY;
      end
    end else if (m_mode == M_PLAY) begin
      if (ev_1 || ev_2) begin
        if (ev_1 && m_s1 < W) m_s1++;
        if (ev_2 && m_s2 < W) m_s2++;
        if (m_s1 == W || m_s2 == W) begin
          m_mode = M_OVER;
          m_win  = (m_s1 == W ? 1 : 0) + (m_s2 == W ? 2 : 0);
        end else begin
          m_mode = M_LOCK;
          m_left = LF;
        end
      end
    end else begin
      if (sk_if.fsync) begin
        m_left--;
        if (m_left == 0) m_mode = M_PLAY;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".p1"},     32'(sk_if.player_1_score), m_s1);
    check_eq({tag, ".p2"},     32'(sk_if.player_2_score), m_s2);
    check_eq({tag, ".winner"}, 32'(sk_if.winner), m_win);
    check_eq({tag, ".over"},   32'(sk_if.game_over), (m_mode == M_OVER) ? 1 : 0);
    check_eq({tag, ".play"},   32'(sk_if.play_en), (m_mode == M_PLAY) ? 1 : 0);
  endtask

  task automatic tick(input string tag);
    @(posedge pixel_clk);
    if (rst) model_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(posedge pixel_clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic hit_pulse(input int who);
    sk_if.p1_hit = (who == 1 || who == 3);
    sk_if.p2_hit = (who == 2 || who == 3);
    tick("hit");
    sk_if.p1_hit = 1'b0;
    sk_if.p2_hit = 1'b0;
  endtask

  // Scores one point and runs fast frames until the model leaves LOCKOUT.
  task automatic score_point(input int who);
    int i;
    hit_pulse(who);
    i = 0;
    while (m_mode == M_LOCK && i < 4 * LF) begin
      sk_if.fsync = (i % 2 == 0);
      tick("lock");
      i++;
    end
    sk_if.fsync = 1'b0;
    if (m_mode == M_LOCK) check_eq("lockout_bound", m_mode, M_PLAY);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got 0 expected 1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sk_if.fsync = 0; sk_if.start = 0; sk_if.p1_hit = 0; sk_if.p2_hit = 0;
    model_reset();

    // Reset state and first start
    repeat (2) @(posedge pixel_clk);
    #1;
    check_all("reset");
    check_eq("reset.play_en", 32'(sk_if.play_en), 0);
    rst = 1'b1;
    tick("idle");
    sk_if.start = 1'b1;
    tick("start");
    check_eq("start.play_en", 32'(sk_if.play_en), 1);
    sk_if.start = 1'b0;
    tick("start_low");

    // Held hit: exactly one point, resume after LF frames
    sk_if.p1_hit = 1'b1;
    for (int i = 0; i < 500; i++) begin
      sk_if.fsync = (i % 5 == 4);
      tick("held");
      if (i == 0) check_eq("held.freeze", 32'(sk_if.play_en), 0);
    end
    sk_if.fsync = 1'b0;
    check_eq("held.score", 32'(sk_if.player_1_score), 1);
    check_eq("held.resumed", 32'(sk_if.play_en), 1);
    sk_if.p1_hit = 1'b0;
    tick("held_drop");

    // Simultaneous winning hits at 8/8 -> draw
    for (int i = 0; i < 7; i++) score_point(1);
    for (int i = 0; i < 8; i++) score_point(2);
    check_eq("pre_draw.p1", 32'(sk_if.player_1_score), 8);
    hit_pulse(3);
    check_eq("draw.p1", 32'(sk_if.player_1_score), 9);
    check_eq("draw.p2", 32'(sk_if.player_2_score), 9);
    check_eq("draw.winner", 32'(sk_if.winner), 3);
    check_eq("draw.over", 32'(sk_if.game_over), 1);
    tick("draw_hold");

    // Restart, 4/8, player 2 wins; OVER ignores hits; start beats hit
    sk_if.start = 1'b1; tick("restart");
    sk_if.start = 1'b0; tick("restart_low");
    for (int i = 0; i < 4; i++) score_point(1);
    for (int i = 0; i < 8; i++) score_point(2);
    score_point(2);
    check_eq("p2win.winner", 32'(sk_if.winner), 2);
    hit_pulse(1); tick("over_gap");
    hit_pulse(2); tick("over_gap");
    check_eq("over_hold.p1", 32'(sk_if.player_1_score), 4);
    check_eq("over_hold.p2", 32'(sk_if.player_2_score), 9);
    sk_if.start = 1'b1; sk_if.p1_hit = 1'b1;
    tick("start_vs_hit");
    check_eq("start_vs_hit.p1", 32'(sk_if.player_1_score), 0);
    check_eq("start_vs_hit.play", 32'(sk_if.play_en), 1);
    sk_if.start = 1'b0; sk_if.p1_hit = 1'b0;
    tick("svh_low");

    // Asynchronous reset mid-LOCKOUT at 3/2
    for (int i = 0; i < 3; i++) score_point(1);
    score_point(2);
    hit_pulse(2);
    for (int i = 0; i < 6; i++) begin
      sk_if.fsync = (i % 2 == 0);
      tick("pre_rst");
    end
    sk_if.fsync = 1'b0;
    check_eq("pre_rst.p2", 32'(sk_if.player_2_score), 2);
    do_reset("rst_async");
    check_eq("rst_async.p1", 32'(sk_if.player_1_score), 0);
    for (int i = 0; i < 40; i++) begin
      sk_if.fsync = (i % 2 == 0);
      tick("post_rst");
    end
    sk_if.fsync = 1'b0;
    check_eq("post_rst.play", 32'(sk_if.play_en), 0);

    // start held through a whole match: no restart until it re-rises
    sk_if.start = 1'b1;
    tick("hold_start");
    for (int i = 0; i < W; i++) score_point(1);
    for (int i = 0; i < 10; i++) tick("hold_over");
    check_eq("hold_start.over", 32'(sk_if.game_over), 1);
    sk_if.start = 1'b0; tick("hold_fall");
    sk_if.start = 1'b1; tick("hold_rise");
    check_eq("hold_rise.play", 32'(sk_if.play_en), 1);
    sk_if.start = 1'b0; tick("hold_done");

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      sk_if.fsync = ($urandom_range(2) == 0);
      if ($urandom_range(7) == 0)  sk_if.p1_hit = ~sk_if.p1_hit;
      if ($urandom_range(7) == 0)  sk_if.p2_hit = ~sk_if.p2_hit;
      if ($urandom_range(39) == 0) sk_if.start  = ~sk_if.start;
      if ($urandom_range(1499) == 0) do_reset("rnd_rst");
      else tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
